// File: rtl/mdu.sv
// mdu: iterative MULT/MULTU/DIV/DIVU plus MTHI/MTLO into HI/LO (clk, rst, start, op[2:0], a, b -> busy, done, hi, lo)
module mdu (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [1:0] op_q, op_d;
  logic sa_q, sa_d, sb_q, sb_d, done_q, done_d;
  logic [31:0] a_q, a_d, m_q, m_d, ph_q, ph_d, pl_q, pl_d, hi_q, hi_d, lo_q, lo_d;
  logic accept, iter, is_signed, last, is_div;
  logic [31:0] abs_a, abs_b, mul_ph, mul_pl, div_ph, div_pl, nx_ph, nx_pl, q_fix, r_fix;
  logic [32:0] sum, sh, diff;
  logic [63:0] prod, prod_fix;
  always_comb begin
    accept = start && state_q == IDLE;
    iter = accept && !op[2];
    is_signed = !op[0];
    abs_a = (is_signed && a[31]) ? -a : a;
    abs_b = (is_signed && b[31]) ? -b : b;
    sum = {1'b0, ph_q} + (pl_q[0] ? {1'b0, m_q} : 33'd0);
    mul_ph = sum[32:1];
    mul_pl = {sum[0], pl_q[31:1]};
    sh = {ph_q, pl_q[31]};
    diff = sh - {1'b0, m_q};
    div_ph = diff[32] ? sh[31:0] : diff[31:0];
    div_pl = {pl_q[30:0], ~diff[32]};
    is_div = op_q[1];
    nx_ph = is_div ? div_ph : mul_ph;
    nx_pl = is_div ? div_pl : mul_pl;
    prod = {nx_ph, nx_pl};
    prod_fix = (sa_q ^ sb_q) ? -prod : prod;
    q_fix = (sa_q ^ sb_q) ? -nx_pl : nx_pl;
    r_fix = sa_q ? -nx_ph : nx_ph;
    last = state_q == RUN && cnt_q == 5'd31;
    state_d = state_q;
    if (state_q == IDLE && iter) state_d = RUN;
    if (last) state_d = IDLE;
    cnt_d = accept ? 5'd0 : (state_q == RUN ? cnt_q + 5'd1 : cnt_q);
    op_d = iter ? op[1:0] : op_q;
    sa_d = iter ? is_signed && a[31] : sa_q;
    sb_d = iter ? is_signed && b[31] : sb_q;
    a_d = iter ? a : a_q;
    m_d = iter ? (op[1] ? abs_b : abs_a) : m_q;
    ph_d = iter ? 32'd0 : (state_q == RUN ? nx_ph : ph_q);
    pl_d = iter ? (op[1] ? abs_a : abs_b) : (state_q == RUN ? nx_pl : pl_q);
    hi_d = last ? (is_div ? (m_q == 32'd0 ? a_q : r_fix) : prod_fix[63:32])
         : (accept && op == 3'b100) ? a : hi_q;
    lo_d = last ? (is_div ? (m_q == 32'd0 ? 32'hFFFFFFFF : q_fix) : prod_fix[31:0])
         : (accept && op == 3'b101) ? a : lo_q;
    done_d = last;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      op_q <= '0;
      sa_q <= 1'b0;
      sb_q <= 1'b0;
      a_q <= '0;
      m_q <= '0;
      ph_q <= '0;
      pl_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      op_q <= op_d;
      sa_q <= sa_d;
      sb_q <= sb_d;
      a_q <= a_d;
      m_q <= m_d;
      ph_q <= ph_d;
      pl_q <= pl_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      done_q <= done_d;
    end
  end
  assign busy = state_q == RUN;
  assign done = done_q;
  assign hi = hi_q;
  assign lo = lo_q;
endmodule

// File: tb/tb_mdu.sv
// tb_mdu: randomized scoreboard bench for mdu against an arithmetic reference model
module tb_mdu;
  logic clk = 0, rst = 1, start = 0, busy, done;
  logic [2:0] op = 0;
  logic [31:0] a = 0, b = 0, hi, lo;
  logic [31:0] m_hi = 0, m_lo = 0;
  logic [63:0] exp_q[$];
  int vecs = 0, errs = 0;
  mdu dut (.clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
           .busy(busy), .done(done), .hi(hi), .lo(lo));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy;
    int ix, iy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ix = x;
    iy = y;
    case (o)
      3'd0: return sx * sy;
      3'd1: return {32'd0, x} * {32'd0, y};
      3'd2: begin
        if (y == 0) return {x, 32'hFFFFFFFF};
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
        return {32'(ix % iy), 32'(ix / iy)};
      end
      3'd3: return (y == 0) ? {x, 32'hFFFFFFFF} : {x % y, x / y};
      default: return 64'd0;
    endcase
  endfunction
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        vecs++;
        errs++;
        $display("FAIL unexpected_done: got done=1 expected no pending result");
      end else chk("result", {hi, lo}, exp_q.pop_front());
    end
  end
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input int intr);
    logic [63:0] e;
    int n;
    @(negedge clk);
    start = 1; op = o; a = x; b = y;
    if (o < 4) begin
      e = model(o, x, y);
      exp_q.push_back(e);
      {m_hi, m_lo} = e;
    end else if (o == 4) m_hi = x;
    else if (o == 5) m_lo = x;
    @(posedge clk);
    #1;
    start = 0; op = 3'($urandom); a = $urandom; b = $urandom;
    if (o < 4) begin
      n = 0;
      @(negedge clk);
      while (busy && n < 40) begin
        n++;
        if (n == intr) begin
          start = 1; op = 3'b001; a = $urandom; b = $urandom;
        end else start = 0;
        @(negedge clk);
      end
      start = 0;
      chk("busy_len", 64'(n), 64'd32);
      chk("done_pulse", {63'd0, done}, 64'd1);
      chk("hilo_commit", {hi, lo}, {m_hi, m_lo});
      @(negedge clk);
      chk("done_end", {63'd0, done}, 64'd0);
    end else begin
      chk("mt_busy_done", {62'd0, busy, done}, 64'd0);
      chk("mt_hilo", {hi, lo}, {m_hi, m_lo});
    end
  endtask
  initial begin
    #1_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    int cnt;
    logic [2:0] o;
    logic [31:0] x, y;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {hi, lo}, 64'd0);
    chk("reset_flags", {62'd0, busy, done}, 64'd0);
    @(negedge clk);
    rst = 0;
    run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    chk("multu_max", {hi, lo}, {32'hFFFFFFFE, 32'h00000001});
    run_op(3'd0, 32'hFFFFFFF9, 32'd3, 0);
    chk("mult_neg", {hi, lo}, {32'hFFFFFFFF, 32'hFFFFFFEB});
    run_op(3'd2, 32'hFFFFFFF9, 32'd2, 0);
    chk("div_neg", {hi, lo}, {32'hFFFFFFFF, 32'hFFFFFFFD});
    run_op(3'd3, 32'd100, 32'd0, 0);
    chk("divu_zero", {hi, lo}, {32'd100, 32'hFFFFFFFF});
    run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 0);
    chk("div_ovf", {hi, lo}, {32'd0, 32'h80000000});
    run_op(3'd4, 32'h12345678, 32'd0, 0);
    run_op(3'd5, 32'hABCDEF01, 32'd0, 0);
    chk("mthi_mtlo", {hi, lo}, {32'h12345678, 32'hABCDEF01});
    run_op(3'd3, 32'd50, 32'd7, 5);
    chk("divu_ignore", {hi, lo}, {32'd1, 32'd7});
    run_op(3'd6, 32'hDEADBEEF, 32'd1, 0);
    @(negedge clk);
    start = 1; op = 3'd0; a = $urandom; b = $urandom;
    @(posedge clk);
    #1;
    start = 0;
    repeat (10) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("abort_state", {hi, lo}, 64'd0);
    chk("abort_flags", {62'd0, busy, done}, 64'd0);
    m_hi = 0; m_lo = 0;
    cnt = 0;
    repeat (35) begin
      @(negedge clk);
      if (done || busy) cnt++;
    end
    chk("abort_quiet", 64'(cnt), 64'd0);
    run_op(3'd0, 32'd12345, 32'hFFFF0000, 0);
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7));
      x = ($urandom_range(0, 5) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 5))
        0: y = 0;
        1: y = 32'hFFFFFFFF;
        2: y = $urandom_range(1, 20);
        default: y = $urandom;
      endcase
      run_op(o, x, y, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 31)) : 0);
    end
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 rst  input  1  synchronous active-high reset, sampled on clk rising edge.
REQ-003 start  input  1  request strobe; accepted on a clk edge only when busy=0.
REQ-004 op  input  3  operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others no-op.
REQ-005 a  input  32  operand 1 (rs); multiplicand or dividend; source value for MTHI/MTLO.
REQ-006 b  input  32  operand 2 (rt); multiplier or divisor.
REQ-007 busy  output  1  high while an iterative operation is in progress; the pipeline stalls on it.
REQ-008 done  output  1  one-cycle pulse when an iterative result is committed to HI/LO.
REQ-009 hi  output  32  HI register; continuously driven for MFHI.
REQ-010 lo  output  32  LO register; continuously driven for MFLO.

Function
REQ-011 The block sits beside the ALU in the execute stage and consumes the same a/b operands; hi/lo feed the writeback mux in parallel with the ALU result.
REQ-012 States: IDLE and RUN; IDLE->RUN on accepted start with op 000-011; RUN->IDLE after exactly 32 RUN cycles; reset forces IDLE.
REQ-013 On acceptance: latch the operands, the op and the sign flags, then clear the iteration counter; the a/b inputs are don't-care after the accepting edge.
REQ-014 busy=1 in every RUN cycle (32 cycles, starting the cycle after the accepting edge) and 0 in IDLE.
REQ-015 On the edge that ends the 32nd RUN cycle: hi/lo are written, busy falls, and done=1 for exactly the following cycle.
REQ-016 start while busy=1 is ignored (no queueing, no effect on the running operation).
REQ-017 MTHI/MTLO: hi<=a or lo<=a on the accepting edge; no busy, no done; the other register is unchanged.
REQ-018 Undefined op with start: no state change, no busy, no done.
REQ-019 MULTU: {hi,lo} = unsigned 64-bit a*b, computed by an iterative radix-2 shift-add (one bit per RUN cycle).
REQ-020 MULT: {hi,lo} = two's-complement 64-bit a*b; magnitudes are multiplied and the product is negated when a[31]^b[31]=1.
REQ-021 DIVU: lo = a/b and hi = a%b (unsigned), computed by restoring division, one quotient bit per RUN cycle.
REQ-022 DIV: the quotient truncates toward zero; the remainder takes the sign of the dividend; the operation uses magnitudes with sign correction in the final cycle.
REQ-023 DIV with a=32'h80000000 and b=32'hFFFFFFFF: lo=32'h80000000, hi=0.
REQ-024 Divide by zero (DIV or DIVU with b=0): the full 32 cycles run, then hi=a and lo=32'hFFFFFFFF.
REQ-025 hi/lo hold their values between writes; only REQ-015 and REQ-017 modify them.
REQ-026 The partial product and partial remainder are not visible on hi/lo until commit.

Reset
REQ-027 rst=1 at an edge: state=IDLE, busy=0, done=0, hi=0, lo=0, and all internal counters and datapath registers are cleared.
REQ-028 Reset asserted during RUN aborts the operation: no commit, no done pulse, and the next cycle is IDLE.
REQ-029 rst has priority over start on the same edge; start is not accepted.

Verification
REQ-030 MULTU a=32'hFFFFFFFF, b=32'hFFFFFFFF -> busy for 32 cycles, then done pulse; hi=32'hFFFFFFFE, lo=32'h00000001.
REQ-031 MULT a=-7 (32'hFFFFFFF9), b=3 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFEB; DIV a=-7, b=2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF.
REQ-032 DIVU a=100, b=0 -> after 32 busy cycles, hi=100 and lo=32'hFFFFFFFF; DIV 32'h80000000 / 32'hFFFFFFFF -> lo=32'h80000000, hi=0.
REQ-033 MTHI a=32'h12345678, then MTLO a=32'hABCDEF01 on consecutive cycles -> hi/lo updated on each edge, busy=0 and done=0 throughout.
REQ-034 DIVU 50/7 started, then start MULTU asserted on busy cycle 5 -> the second request is ignored; result lo=7, hi=1.
REQ-035 MULT started, rst asserted on busy cycle 10 -> busy=0 and hi=lo=0 on the next cycle; no done pulse; a new start is then accepted normally.
